// File: rtl/axi_wstrb_merge.sv
// AXI write-data byte-lane merge: accumulates strobed beats into one word and
// emits it with its cumulative byte mask. Byte overwrites within a word are flagged and counted.
module axi_wstrb_merge #(
    parameter int DATA_W        = 64,
    parameter int STRB_W        = DATA_W / 8,
    parameter bit MERGE_ON_FULL = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wlast,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [STRB_W-1:0] m_strb,
    output logic              m_last,
    output logic              overlap,
    output logic [CNT_W-1:0]  overlap_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_acc_data;
    logic [STRB_W-1:0]  r_acc_mask;
    logic               r_m_valid;
    logic               r_m_last;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_overlap_cnt;

    logic               w_accept;
    logic               w_handoff;
    logic               w_close;
    logic               w_hit;
    logic [STRB_W-1:0]  w_nm;
    logic [DATA_W-1:0]  w_merged;

    assign s_wready  = (r_state != HOLD);
    assign w_accept  = s_wvalid & s_wready;
    assign w_handoff = (r_state == HOLD) & m_ready;
    assign w_nm      = r_acc_mask | s_wstrb;
    assign w_hit     = |(s_wstrb & r_acc_mask);

    always_comb begin
        w_merged = r_acc_data;
        for (int i = 0; i < STRB_W; i++) begin
            if (s_wstrb[i]) begin
                w_merged[8*i +: 8] = s_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_close     = 1'b0;
        case (r_state)
            EMPTY, ACCUM: begin
                if (w_accept) begin
                    if (s_wlast || flush || (MERGE_ON_FULL && (&w_nm))) begin
                        w_close     = 1'b1;
                        w_state_nxt = HOLD;
                    end else if (w_nm != '0) begin
                        w_state_nxt = ACCUM;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end else if (flush && (r_state == ACCUM)) begin
                    // Flush of a partial word carries no burst framing.
                    w_close     = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= EMPTY;
            r_acc_data    <= '0;
            r_acc_mask    <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_overlap     <= 1'b0;
            r_overlap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_overlap <= w_accept & w_hit;
            if (w_accept && w_hit && (r_overlap_cnt != {CNT_W{1'b1}})) begin
                r_overlap_cnt <= r_overlap_cnt + CNT_W'(1);
            end
            if (w_handoff) begin
                r_acc_data <= '0;
                r_acc_mask <= '0;
                r_m_valid  <= 1'b0;
                r_m_last   <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc_data <= w_merged;
                    r_acc_mask <= w_nm;
                end
                if (w_close) begin
                    r_m_valid <= 1'b1;
                    r_m_last  <= w_accept & s_wlast;
                end
            end
        end
    end

    assign m_valid     = r_m_valid;
    assign m_data      = r_acc_data;
    assign m_strb      = r_acc_mask;
    assign m_last      = r_m_last;
    assign overlap     = r_overlap;
    assign overlap_cnt = r_overlap_cnt;

endmodule

// File: doc/axi_wstrb_merge.md
Name: axi_wstrb_merge

Overview:
- Parametrised AXI write-data byte-lane merge stage for the write datapath.
- Accepts W-channel beats with per-byte strobes and accumulates enabled lanes into one merge register.
- Emits a single merged word with its cumulative strobe mask over a valid/ready interface.
- A word closes on the last beat, on full-lane coverage (optional), or on an explicit flush. It also detects and counts byte overwrites within one merge.

Parameters:
- DATA_W, 64: data width in bits. Must be a multiple of 8 and at least 8.
- STRB_W, DATA_W/8: strobe width in bytes. Derived; do not override.
- MERGE_ON_FULL, 1: when 1, a word closes as soon as the cumulative mask becomes all ones.
- CNT_W, 16: width of the overlap counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- s_wvalid  in  1  input beat valid
- s_wready  out  1  input beat ready
- s_wdata  in  DATA_W  input beat data
- s_wstrb  in  STRB_W  input byte enables
- s_wlast  in  1  last beat of burst
- flush  in  1  close the current partial word
- m_valid  out  1  merged word valid
- m_ready  in  1  merged word accepted downstream
- m_data  out  DATA_W  merged data; unwritten lanes are 0
- m_strb  out  STRB_W  cumulative byte mask
- m_last  out  1  word closed by s_wlast
- overlap  out  1  one-cycle pulse on byte overwrite
- overlap_cnt  out  CNT_W  saturating count of overwrite events

Behaviour:
- Reset, sampled at a clk edge with rst_n=0:
  - State goes to EMPTY.
  - acc_data=0, acc_mask=0.
  - m_valid=0, m_last=0, overlap=0, overlap_cnt=0.
  - A reset during ACCUM or HOLD discards the partial or held word with no output.
- States:
  - EMPTY: acc_mask==0.
  - ACCUM: acc_mask!=0, word still open.
  - HOLD: word closed, m_valid=1.
- s_wready = 1 in EMPTY and ACCUM; 0 in HOLD. s_wready is combinational from state only and never depends on s_wvalid.
- Beat accepted (s_wvalid & s_wready):
  - For each lane i with s_wstrb[i]=1, acc_data[8i+7:8i] <= s_wdata lane i.
  - Lanes with strobe 0 keep their value.
  - acc_mask <= acc_mask | s_wstrb.
- Close condition on an accepted beat, where nm = acc_mask | s_wstrb:
  - Close if s_wlast, or if (MERGE_ON_FULL & nm all ones), or if flush is high in the same cycle. Next state is HOLD.
  - Otherwise the next state is ACCUM when nm != 0, else EMPTY (an all-zero-strobe beat is absorbed).
  - s_wlast with nm==0 still closes: the emitted word has m_strb=0, m_data=0, m_last=1, so burst framing is preserved.
- flush with no accepted beat:
  - In ACCUM: go to HOLD with m_last=0.
  - In EMPTY or HOLD: ignored.
- m_last <= s_wlast of the closing beat; it is 0 for flush or full-coverage closes.
- HOLD:
  - m_valid=1.
  - m_data, m_strb and m_last are registered and stable until m_ready.
  - On m_valid & m_ready: acc_data <= 0, acc_mask <= 0, m_valid <= 0, next state EMPTY.
  - Because s_wready=0 in HOLD, no beat is accepted in the handoff cycle.
- Timing:
  - Closing beat accepted at edge N means m_valid=1 from N+1.
  - Throughput is one beat per cycle while accumulating, plus one bubble per emitted word.
- Overlap:
  - An accepted beat with (s_wstrb & acc_mask) != 0 sets overlap=1 for the next cycle only. The later byte wins.
  - overlap_cnt increments by 1 per such beat and saturates at 2^CNT_W-1.
  - overlap_cnt is cleared only by reset.
- All outputs except s_wready are registered.

Test Plan:
- Single full beat: wdata=64'h1122334455667788, wstrb=8'hFF, wlast=0 -> next cycle m_valid=1, m_data=64'h1122334455667788, m_strb=FF, m_last=0, s_wready=0.
- Two partial beats: wstrb=0F with data ..._AABBCCDD, then wstrb=F0 with data 0x11223344_... -> one output word 64'h11223344AABBCCDD, m_strb=FF, emitted after the second beat.
- Overlap: wstrb=03 data ..0x1234, then wstrb=01 data ..0x56 with wlast=1 -> m_data=64'h1256, m_strb=03, m_last=1, overlap pulses 1 cycle, overlap_cnt=1.
- Flush and backpressure: wstrb=0x0C beat, then flush, hold m_ready=0 for 5 cycles -> m_valid=1 with m_strb=0C steady, s_wready=0 throughout; m_ready=1 -> EMPTY next cycle.
- Zero-strobe last: single beat wstrb=00, wlast=1 -> m_valid=1, m_strb=00, m_data=0, m_last=1.
- Reset mid-operation: wstrb=0F accepted, rst_n=0 one edge -> m_valid=0, overlap_cnt=0. A subsequent FF beat emits only the new data.
